wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter.sv | 119 +++++++++++
 tb/tb_wb_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// Writeback arbiter: grants one of the ALU/LSU requests per cycle onto a registered RF write port.
// Define WB_SCOREBOARD_EN to build the pending-write scoreboard and decode stall.
module wb_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        alu_valid_i,
  input  logic [4:0]  alu_rd_i,
  input  logic [31:0] alu_data_i,
  output logic        alu_ready_o,
  input  logic        lsu_valid_i,
  input  logic [4:0]  lsu_rd_i,
  input  logic [31:0] lsu_data_i,
  output logic        lsu_ready_o,
  input  logic        issue_i,
  input  logic [4:0]  issue_rd_i,
  input  logic [4:0]  RS1addr_i,
  input  logic [4:0]  RS2addr_i,
  output logic        RegWrite_o,
  output logic [4:0]  RDaddr_o,
  output logic [31:0] RDdata_o,
  output logic        stall_o,
  output logic [31:0] busy_o
);

  localparam logic [3:0] StarveMax = 4'(STARVE_LIMIT);

  logic [3:0]  starve_q, starve_d;
  logic        regwrite_q, regwrite_d;
  logic [4:0]  rdaddr_q, rdaddr_d;
  logic [31:0] rddata_q, rddata_d;
  logic        alu_force, alu_grant, lsu_grant;

  always_comb begin
    alu_force = alu_valid_i && (starve_q == StarveMax);
    // Readies are gated by reset so nothing is accepted while rst_n is low.
    alu_grant = rst_n && alu_valid_i && (!lsu_valid_i || alu_force);
    lsu_grant = rst_n && lsu_valid_i && !alu_force;
  end

  assign alu_ready_o = alu_grant;
  assign lsu_ready_o = lsu_grant;

  always_comb begin
    starve_d = '0;
    if (alu_valid_i && !alu_grant) begin
      starve_d = (starve_q == StarveMax) ? starve_q : starve_q + 4'd1;
    end
  end

  always_comb begin
    regwrite_d = 1'b0;
    rdaddr_d   = rdaddr_q;
    rddata_d   = rddata_q;
    if (lsu_grant) begin
      regwrite_d = (lsu_rd_i != 5'd0);
      rdaddr_d   = lsu_rd_i;
      rddata_d   = lsu_data_i;
    end else if (alu_grant) begin
      regwrite_d = (alu_rd_i != 5'd0);
      rdaddr_d   = alu_rd_i;
      rddata_d   = alu_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_q   <= '0;
      regwrite_q <= 1'b0;
      rdaddr_q   <= '0;
      rddata_q   <= '0;
    end else begin
      starve_q   <= starve_d;
      regwrite_q <= regwrite_d;
      rdaddr_q   <= rdaddr_d;
      rddata_q   <= rddata_d;
    end
  end

  assign RegWrite_o = regwrite_q;
  assign RDaddr_o   = rdaddr_q;
  assign RDdata_o   = rddata_q;

`ifdef WB_SCOREBOARD_EN
  logic [31:0] busy_q, busy_d;
  logic        bypass1, bypass2;

  always_comb begin
    busy_d = busy_q;
    if (regwrite_q) busy_d[rdaddr_q] = 1'b0;
    // Applied after the clear so a same-register set wins.
    if (issue_i) busy_d[issue_rd_i] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  always_comb begin
    bypass1 = regwrite_q && (rdaddr_q == RS1addr_i);
    bypass2 = regwrite_q && (rdaddr_q == RS2addr_i);
    stall_o = rst_n && ((busy_q[RS1addr_i] && !bypass1) || (busy_q[RS2addr_i] && !bypass2));
  end

  assign busy_o = busy_q;
`else
  logic unused_sb;
  assign unused_sb = ^{issue_i, issue_rd_i, RS1addr_i, RS2addr_i};
  assign busy_o    = '0;
  assign stall_o   = 1'b0;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed table, corner sequences, and a randomized
// run against a behavioural model. Scoreboard checks follow WB_SCOREBOARD_EN.
module tb_wb_arbiter;
  localparam int unsigned Limit = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid_i, lsu_valid_i, issue_i;
  logic [4:0]  alu_rd_i, lsu_rd_i, issue_rd_i, RS1addr_i, RS2addr_i;
  logic [31:0] alu_data_i, lsu_data_i;
  logic        alu_ready_o, lsu_ready_o, RegWrite_o, stall_o;
  logic [4:0]  RDaddr_o;
  logic [31:0] RDdata_o, busy_o;

  int total = 0;
  int bad = 0;

  wb_arbiter #(.STARVE_LIMIT(Limit)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid_i(alu_valid_i), .alu_rd_i(alu_rd_i), .alu_data_i(alu_data_i),
    .alu_ready_o(alu_ready_o),
    .lsu_valid_i(lsu_valid_i), .lsu_rd_i(lsu_rd_i), .lsu_data_i(lsu_data_i),
    .lsu_ready_o(lsu_ready_o),
    .issue_i(issue_i), .issue_rd_i(issue_rd_i), .RS1addr_i(RS1addr_i), .RS2addr_i(RS2addr_i),
    .RegWrite_o(RegWrite_o), .RDaddr_o(RDaddr_o), .RDdata_o(RDdata_o),
    .stall_o(stall_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clear_in();
    alu_valid_i = 0; alu_rd_i = 0; alu_data_i = 0;
    lsu_valid_i = 0; lsu_rd_i = 0; lsu_data_i = 0;
    issue_i = 0; issue_rd_i = 0; RS1addr_i = 0; RS2addr_i = 0;
  endtask

  task automatic to_neg();
    @(negedge clk);
  endtask

  task automatic to_post();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        av;
    logic [4:0]  ard;
    logic [31:0] ad;
    logic        lv;
    logic [4:0]  lrd;
    logic [31:0] ld;
    logic        e_ar;
    logic        e_lr;
    logic        e_we;
    logic        chk_ad;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
  } vec_t;

  vec_t vecs[7];

  // Behavioural model state for the randomized run.
  int          m_starve;
  logic        m_we, m_known;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  logic [31:0] m_busy;

  initial begin
    logic e_ar, e_lr, e_stall, alu_win;
    vecs[0] = '{1'b1, 5'd5, 32'h12345678, 1'b0, 5'd0, 32'h0,
                1'b1, 1'b0, 1'b1, 1'b1, 5'd5, 32'h12345678};
    vecs[1] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 32'h12345678};
    vecs[2] = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 32'hdeadbeef,
                1'b0, 1'b1, 1'b1, 1'b1, 5'd3, 32'hdeadbeef};
    vecs[3] = '{1'b1, 5'd1, 32'h1, 1'b1, 5'd2, 32'h2,
                1'b0, 1'b1, 1'b1, 1'b1, 5'd2, 32'h2};
    vecs[4] = '{1'b1, 5'd4, 32'h80000004, 1'b0, 5'd0, 32'h0,
                1'b1, 1'b0, 1'b1, 1'b1, 5'd4, 32'h80000004};
    vecs[5] = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'hffff,
                1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0};
    vecs[6] = '{1'b1, 5'd0, 32'h5, 1'b0, 5'd0, 32'h0,
                1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0};

    // Reset with requests present: nothing accepted.
    clear_in();
    rst_n = 0; alu_valid_i = 1; lsu_valid_i = 1; alu_rd_i = 3; lsu_rd_i = 4;
    issue_i = 1; issue_rd_i = 3; RS1addr_i = 3;
    to_post(); to_post();
    to_neg();
    check("rst_alu_ready", {31'b0, alu_ready_o}, 0);
    check("rst_lsu_ready", {31'b0, lsu_ready_o}, 0);
    check("rst_stall", {31'b0, stall_o}, 0);
    to_post();
    check("rst_we", {31'b0, RegWrite_o}, 0);
    check("rst_addr", {27'b0, RDaddr_o}, 0);
    check("rst_data", RDdata_o, 0);
    check("rst_busy", busy_o, 0);
    clear_in();
    rst_n = 1;

    foreach (vecs[i]) begin
      alu_valid_i = vecs[i].av; alu_rd_i = vecs[i].ard; alu_data_i = vecs[i].ad;
      lsu_valid_i = vecs[i].lv; lsu_rd_i = vecs[i].lrd; lsu_data_i = vecs[i].ld;
      to_neg();
      check($sformatf("vec%0d_alu_ready", i), {31'b0, alu_ready_o}, {31'b0, vecs[i].e_ar});
      check($sformatf("vec%0d_lsu_ready", i), {31'b0, lsu_ready_o}, {31'b0, vecs[i].e_lr});
      to_post();
      check($sformatf("vec%0d_we", i), {31'b0, RegWrite_o}, {31'b0, vecs[i].e_we});
      if (vecs[i].chk_ad) begin
        check($sformatf("vec%0d_addr", i), {27'b0, RDaddr_o}, {27'b0, vecs[i].e_addr});
        check($sformatf("vec%0d_data", i), RDdata_o, vecs[i].e_data);
      end
    end
    clear_in();

    // Starvation: both valid for 10 cycles, ALU forced through every fifth cycle.
    for (int i = 0; i < 10; i++) begin
      alu_valid_i = 1; alu_rd_i = 1; alu_data_i = i;
      lsu_valid_i = 1; lsu_rd_i = 2; lsu_data_i = 100 + i;
      to_neg();
      check($sformatf("starve%0d_alu", i), {31'b0, alu_ready_o}, (i == 4 || i == 9) ? 1 : 0);
      check($sformatf("starve%0d_lsu", i), {31'b0, lsu_ready_o}, (i == 4 || i == 9) ? 0 : 1);
      to_post();
      check($sformatf("starve%0d_addr", i), {27'b0, RDaddr_o}, (i == 4 || i == 9) ? 1 : 2);
    end
    clear_in();

`ifdef WB_SCOREBOARD_EN
    issue_i = 1; issue_rd_i = 7;
    to_post();
    check("sb_busy7_set", {31'b0, busy_o[7]}, 1);
    clear_in();
    RS1addr_i = 7; lsu_valid_i = 1; lsu_rd_i = 7; lsu_data_i = 32'h77;
    to_neg();
    check("sb_stall_pending", {31'b0, stall_o}, 1);
    to_post();
    check("sb_we7", {31'b0, RegWrite_o}, 1);
    check("sb_busy7_held", {31'b0, busy_o[7]}, 1);
    lsu_valid_i = 0;
    to_neg();
    check("sb_stall_bypass", {31'b0, stall_o}, 0);
    to_post();
    check("sb_busy7_clear", {31'b0, busy_o[7]}, 0);
    to_neg();
    check("sb_stall_after", {31'b0, stall_o}, 0);
    clear_in();
    issue_i = 1; issue_rd_i = 9;
    to_post();
    clear_in();
    lsu_valid_i = 1; lsu_rd_i = 9; lsu_data_i = 9; RS2addr_i = 9;
    to_neg();
    check("sb_stall_rs2", {31'b0, stall_o}, 1);
    to_post();
    clear_in();
    issue_i = 1; issue_rd_i = 9;
    to_post();
    check("sb_set_wins", {31'b0, busy_o[9]}, 1);
    clear_in();
    RS2addr_i = 9;
    to_neg();
    check("sb_stall_again", {31'b0, stall_o}, 1);
    clear_in();
    issue_i = 1; issue_rd_i = 0;
    to_post();
    check("sb_busy0", {31'b0, busy_o[0]}, 0);
`else
    issue_i = 1; issue_rd_i = 7; RS1addr_i = 7; RS2addr_i = 7;
    to_post();
    issue_i = 0;
    to_neg();
    check("nosb_stall", {31'b0, stall_o}, 0);
    check("nosb_busy", busy_o, 0);
`endif
    clear_in();

    // Grant to rd 0: accepted, no write pulse.
    alu_valid_i = 1; alu_rd_i = 0; alu_data_i = 32'habc;
    to_neg();
    check("rd0_ready", {31'b0, alu_ready_o}, 1);
    to_post();
    check("rd0_we", {31'b0, RegWrite_o}, 0);

    // Reset with a write in flight.
    alu_valid_i = 1; alu_rd_i = 6; alu_data_i = 32'h66;
    issue_i = 1; issue_rd_i = 12;
    to_post();
    check("inflight_we", {31'b0, RegWrite_o}, 1);
    rst_n = 0; issue_i = 0; lsu_valid_i = 1; lsu_rd_i = 8;
    to_neg();
    check("midrst_alu_ready", {31'b0, alu_ready_o}, 0);
    check("midrst_lsu_ready", {31'b0, lsu_ready_o}, 0);
    check("midrst_stall", {31'b0, stall_o}, 0);
    to_post();
    check("midrst_we", {31'b0, RegWrite_o}, 0);
    check("midrst_busy", busy_o, 0);
    check("midrst_data", RDdata_o, 0);
    clear_in();
    rst_n = 1;
    to_post();
    check("postrst_we", {31'b0, RegWrite_o}, 0);

    // Randomized run against the model.
    m_starve = 0; m_we = 0; m_known = 1; m_addr = 0; m_data = 0; m_busy = 0;
    for (int c = 0; c < 600; c++) begin
      rst_n       = ($urandom_range(0, 49) != 0);
      alu_valid_i = ($urandom_range(0, 9) < 6);
      lsu_valid_i = ($urandom_range(0, 9) < 5);
      alu_rd_i    = 5'($urandom_range(0, 7));
      lsu_rd_i    = 5'($urandom_range(0, 7));
      alu_data_i  = $urandom;
      lsu_data_i  = $urandom;
      issue_i     = ($urandom_range(0, 9) < 4);
      issue_rd_i  = 5'($urandom_range(0, 7));
      RS1addr_i   = 5'($urandom_range(0, 7));
      RS2addr_i   = 5'($urandom_range(0, 7));

      alu_win = alu_valid_i && (!lsu_valid_i || m_starve == Limit);
      e_ar = rst_n && alu_win;
      e_lr = rst_n && lsu_valid_i && !alu_win;
`ifdef WB_SCOREBOARD_EN
      e_stall = rst_n && ((m_busy[RS1addr_i] && !(m_we && m_addr == RS1addr_i)) ||
                          (m_busy[RS2addr_i] && !(m_we && m_addr == RS2addr_i)));
`else
      e_stall = 0;
`endif
      to_neg();
      check("rnd_alu_ready", {31'b0, alu_ready_o}, {31'b0, e_ar});
      check("rnd_lsu_ready", {31'b0, lsu_ready_o}, {31'b0, e_lr});
      check("rnd_stall", {31'b0, stall_o}, {31'b0, e_stall});
      to_post();

      if (!rst_n) begin
        m_starve = 0; m_we = 0; m_known = 1; m_addr = 0; m_data = 0; m_busy = 0;
      end else begin
`ifdef WB_SCOREBOARD_EN
        if (m_we) m_busy[m_addr] = 0;
        if (issue_i && issue_rd_i != 0) m_busy[issue_rd_i] = 1;
`endif
        if (alu_valid_i && !e_ar) m_starve = (m_starve < Limit) ? m_starve + 1 : Limit;
        else m_starve = 0;
        m_we = 0;
        if (e_ar || e_lr) begin
          m_addr  = e_lr ? lsu_rd_i : alu_rd_i;
          m_data  = e_lr ? lsu_data_i : alu_data_i;
          m_we    = (m_addr != 0);
          m_known = m_we;
        end
      end
      check("rnd_we", {31'b0, RegWrite_o}, {31'b0, m_we});
      if (m_known) begin
        check("rnd_addr", {27'b0, RDaddr_o}, {27'b0, m_addr});
        check("rnd_data", RDdata_o, m_data);
      end
      check("rnd_busy", busy_o, m_busy);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
